serial_add: RTL and testbench
=============================

Name: serial_add

Overview:
- Parametrised, bit-serial successor to the 1-bit combinational adder.
- Adds two WIDTH-bit operands LSB-first, one bit per clock, through a single full-adder cell and a carry flop. This is the same shift-register style as the UART datapath.
- Valid/ready handshake on both input and output.
- Used wherever area matters more than latency, e.g. checksum accumulation on received UART bytes.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operands a/b present
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  sum/carry valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  registered result
- carry  out  1  registered carry-out of MSB

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, carry=0, internal shift regs=0, bit counter=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a and b into shift regs, clear carry flop, clear counter, go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle: s = a_sh[0] ^ b_sh[0] ^ c; c' = majority(a_sh[0], b_sh[0], c).
  - a_sh and b_sh shift right by one; s shifts into the MSB of the result shift reg; counter increments.
  - When counter reaches WIDTH-1 on a shift edge, that edge also loads sum and carry from the completed result and c', and goes to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - sum and carry stay stable while out_ready=0.
  - On out_ready=1: out_valid drops next cycle, go to IDLE.
  - No acceptance in the same cycle as the result handoff.
- Latency: operands accepted at edge N -> out_valid high from edge N+WIDTH.
  - Minimum issue interval is WIDTH+2 cycles.
- sum and carry change only on the SHIFT->DONE edge or on reset. They hold the last result through IDLE and SHIFT.
- in_valid in SHIFT or DONE is ignored; the operands are not queued.
- Arithmetic: unsigned modulo 2^WIDTH; carry is the true bit WIDTH of a+b.
- Counter width is clog2(WIDTH+1); no overflow for any legal WIDTH.
- WIDTH=1: single SHIFT cycle; result matches a full adder with cin=0.
- rst in any state, including mid-SHIFT or DONE with out_ready=0:
  - abort the operation and return all regs to reset values at that edge;
  - the partial result is discarded, never presented.
- rst has priority over in_valid and out_ready in the same cycle.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), sampled together with a and b on acceptance.
  - sub=1 inverts b on capture and presets the carry flop to 1, giving sum = a - b mod 2^WIDTH.
  - carry=1 means no borrow (a>=b).
  - sub=0 behaves exactly as add.
  - Latency is unchanged.
- Not defined: port sub is absent; add only.

Test Plan:
- WIDTH=8, rst held 2 cycles, then a=0x03, b=0x05, out_ready=1 -> out_valid rises 8 cycles after acceptance, sum=0x08, carry=0, then IDLE with in_ready=1.
- WIDTH=8, a=0xFF, b=0x01, then a=0x80, b=0x80 -> sum=0x00 carry=1 for both. Also 0xA5+0x5A -> sum=0xFF carry=0.
- Backpressure: 0x12+0x34 with out_ready=0 for 5 cycles after out_valid -> sum=0x46 and out_valid held stable all 5 cycles, in_ready=0. Pulse in_valid with 0x01+0x01 during this window -> ignored; next result is still 0x46.
- Reset mid-op: accept 0x0F+0x01, assert rst on 3rd SHIFT cycle -> next cycle out_valid=0, sum=0, carry=0, in_ready=1. A fresh 0x02+0x02 then yields 0x04.
- WIDTH=1 instance, exhaustive a,b in {0,1} -> (sum,carry) = (0,0),(1,0),(1,0),(0,1), each 1 cycle after acceptance.
- SERIAL_ADD_SUB_EN, WIDTH=8:
  - sub=1, 7-5 -> sum=0x02 carry=1.
  - sub=1, 5-7 -> sum=0xFE carry=0.
  - sub=0, 5+7 -> sum=0x0C carry=0.

Source files
------------

// File: rtl/serial_add.sv
// Bit-serial adder: LSB-first through one full-adder cell and a carry flop, valid/ready on both
// sides. Optional subtract mode when SERIAL_ADD_SUB_EN is defined (adds input port sub).
module serial_add #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_q, res_next, b_cap;
  logic [WIDTH-1:0] sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             c_q, carry_q;
  logic             accept, last, s_bit, c_next, sub_en;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_en = sub;
`else
  assign sub_en = 1'b0;
`endif

  // Subtract is a + ~b + 1: invert b on capture and preset the carry flop.
  assign b_cap    = sub_en ? ~b : b;
  assign accept   = in_valid && (state_q == StIdle);
  assign last     = (state_q == StShift) && (cnt_q == CntW'(WIDTH - 1));
  assign s_bit    = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
  assign c_next   = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
  // Shift-based form stays legal for WIDTH=1, where a slice would collapse.
  assign res_next = (res_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StShift;
      StShift: if (last) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      a_sh_q <= a;
      b_sh_q <= b_cap;
      res_q  <= '0;
      c_q    <= sub_en;
      cnt_q  <= '0;
    end else if (state_q == StShift) begin
      a_sh_q <= a_sh_q >> 1;
      b_sh_q <= b_sh_q >> 1;
      res_q  <= res_next;
      c_q    <= c_next;
      cnt_q  <= cnt_q + 1'b1;
      if (last) begin
        sum_q   <= res_next;
        carry_q <= c_next;
      end
    end
  end

  assign sum   = sum_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_serial_add.sv
// Randomized and directed bench for serial_add (WIDTH=8 and WIDTH=1 instances), checked every
// cycle against an arithmetic reference model; define SERIAL_ADD_SUB_EN to cover subtract mode.
module tb_serial_add;

`ifdef SERIAL_ADD_SUB_EN
  localparam bit HasSub = 1'b1;
`else
  localparam bit HasSub = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       iv8, ir8, ov8, or8, c8, sub8;
  logic [7:0] a8, b8, s8;
  logic       iv1, ir1, ov1, or1, c1, sub1;
  logic [0:0] a1, b1, s1;

  int n_vec = 0;
  int n_err = 0;

  serial_add #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub8),
`endif
    .out_valid(ov8), .out_ready(or8), .sum(s8), .carry(c8)
  );

  serial_add #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub1),
`endif
    .out_valid(ov1), .out_ready(or1), .sum(s1), .carry(c1)
  );

  // Reference: an accepted op becomes visible exactly w edges later; result is plain arithmetic.
  typedef struct {
    bit          busy;
    bit          done;
    int          left;
    logic [64:0] pend;
    logic [63:0] sum;
    bit          carry;
  } mdl_t;

  mdl_t m8, m1;

  function automatic mdl_t mdl_step(mdl_t m, int w, logic r, logic iv, logic ordy,
                                    logic [63:0] a, logic [63:0] b, logic sb);
    logic [64:0] mask;
    mdl_t n;
    mask = (65'd1 << w) - 65'd1;
    n = m;
    if (r) begin
      n.busy = 0; n.done = 0; n.left = 0; n.sum = '0; n.carry = 0;
    end else if (m.done) begin
      if (ordy) n.done = 0;
    end else if (m.busy) begin
      n.left = m.left - 1;
      if (n.left == 0) begin
        n.busy  = 0;
        n.done  = 1;
        n.sum   = 64'(m.pend & mask);
        n.carry = m.pend[w];
      end
    end else if (iv) begin
      n.busy = 1;
      n.left = w;
      if (sb) n.pend = ({1'b0, a} & mask) + (~{1'b0, b} & mask) + 65'd1;
      else    n.pend = ({1'b0, a} & mask) + ({1'b0, b} & mask);
    end
    return n;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("in_ready8",  64'(ir8), 64'(!m8.busy && !m8.done));
    chk("out_valid8", 64'(ov8), 64'(m8.done));
    chk("sum8",       64'(s8),  m8.sum);
    chk("carry8",     64'(c8),  64'(m8.carry));
    chk("in_ready1",  64'(ir1), 64'(!m1.busy && !m1.done));
    chk("out_valid1", 64'(ov1), 64'(m1.done));
    chk("sum1",       64'(s1),  m1.sum);
    chk("carry1",     64'(c1),  64'(m1.carry));
  endtask

  // Advance one clock: model sees the same inputs as the DUTs, compare on the falling edge.
  task automatic step();
    @(posedge clk);
    m8 = mdl_step(m8, 8, rst, iv8, or8, 64'(a8), 64'(b8), sub8);
    m1 = mdl_step(m1, 1, rst, iv1, or1, 64'(a1), 64'(b1), sub1);
    @(negedge clk);
    compare();
  endtask

  task automatic op(bit sel, logic [63:0] a, logic [63:0] b, logic sb,
                    logic [63:0] es, logic ec, string name);
    int k;
    k = 0;
    while (!(sel ? ir1 : ir8) && k < 50) begin step(); k++; end
    if (sel) begin iv1 = 1; a1 = a[0:0]; b1 = b[0:0]; sub1 = sb; end
    else     begin iv8 = 1; a8 = a[7:0]; b8 = b[7:0]; sub8 = sb; end
    step();
    iv1 = 0; iv8 = 0;
    k = 0;
    while (!(sel ? ov1 : ov8) && k < 100) begin step(); k++; end
    chk({name, "_latency"}, 64'(k), sel ? 64'd1 : 64'd8);
    chk({name, "_sum"}, sel ? 64'(s1) : 64'(s8), es);
    chk({name, "_carry"}, sel ? 64'(c1) : 64'(c8), 64'(ec));
    step();
    chk({name, "_idle_ready"}, sel ? 64'(ir1) : 64'(ir8), 64'd1);
  endtask

  initial begin
    int k;
    m8 = '{busy: 0, done: 0, left: 0, pend: '0, sum: '0, carry: 0};
    m1 = m8;
    rst = 1; iv8 = 0; a8 = '0; b8 = '0; or8 = 1; sub8 = 0;
    iv1 = 0; a1 = '0; b1 = '0; or1 = 1; sub1 = 0;
    step(); step();
    chk("reset_in_ready", 64'(ir8), 64'd1);
    chk("reset_out_valid", 64'(ov8), 64'd0);
    chk("reset_sum", 64'(s8), 64'd0);
    rst = 0;

    op(0, 64'h03, 64'h05, 0, 64'h08, 0, "add_03_05");
    op(0, 64'hFF, 64'h01, 0, 64'h00, 1, "add_ff_01");
    op(0, 64'h80, 64'h80, 0, 64'h00, 1, "add_80_80");
    op(0, 64'hA5, 64'h5A, 0, 64'hFF, 0, "add_a5_5a");

    // Backpressure with an in_valid pulse that must be ignored.
    or8 = 0; iv8 = 1; a8 = 8'h12; b8 = 8'h34;
    step();
    iv8 = 0;
    k = 0;
    while (!ov8 && k < 100) begin step(); k++; end
    chk("bp_latency", 64'(k), 64'd8);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin iv8 = 1; a8 = 8'h01; b8 = 8'h01; end
      step();
      iv8 = 0;
      chk("bp_sum_held", 64'(s8), 64'h46);
      chk("bp_valid_held", 64'(ov8), 64'd1);
      chk("bp_not_ready", 64'(ir8), 64'd0);
    end
    or8 = 1;
    step();
    chk("bp_valid_drop", 64'(ov8), 64'd0);
    chk("bp_sum_kept", 64'(s8), 64'h46);

    // Reset in the third SHIFT cycle discards the partial result.
    iv8 = 1; a8 = 8'h0F; b8 = 8'h01;
    step();
    iv8 = 0;
    step(); step();
    rst = 1;
    step();
    rst = 0;
    chk("midrst_valid", 64'(ov8), 64'd0);
    chk("midrst_sum", 64'(s8), 64'd0);
    chk("midrst_carry", 64'(c8), 64'd0);
    chk("midrst_ready", 64'(ir8), 64'd1);
    op(0, 64'h02, 64'h02, 0, 64'h04, 0, "after_rst");

    // WIDTH=1 exhaustive.
    for (int i = 0; i < 4; i++) begin
      logic [63:0] va, vb;
      va = 64'(i & 1);
      vb = 64'(i >> 1);
      op(1, va, vb, 0, (va + vb) & 64'd1, ((va + vb) >> 1) != 0, "w1");
    end

`ifdef SERIAL_ADD_SUB_EN
    op(0, 64'h07, 64'h05, 1, 64'h02, 1, "sub_7_5");
    op(0, 64'h05, 64'h07, 1, 64'hFE, 0, "sub_5_7");
    op(0, 64'h05, 64'h07, 0, 64'h0C, 0, "add_5_7");
`endif

    // Random traffic on both instances, occasional resets and backpressure.
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      iv8  = 1'($urandom);
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      or8  = ($urandom_range(0, 3) != 0);
      sub8 = HasSub ? 1'($urandom) : 1'b0;
      iv1  = 1'($urandom);
      a1   = 1'($urandom);
      b1   = 1'($urandom);
      or1  = ($urandom_range(0, 3) != 0);
      sub1 = HasSub ? 1'($urandom) : 1'b0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
